telemetry_sched: RTL

Periodic telemetry scheduler for the eBike TX line. Snapshots battery, current and torque readings and sequences them into a fixed 8-byte packet. Each byte is handed to the existing UART_tx over its trmt/tx_done handshake. Sits between the A2D readback registers and UART_tx in eBike, so the UART_rcv monitor in the benches can decode packets.

---
 rtl/telem_pkg.sv | 37 +++
 rtl/telem_timer.sv | 30 +++
 rtl/telemetry_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/telem_pkg.sv
// Shared constants, state encoding and packet byte selection for the telemetry scheduler.
package telem_pkg;

    localparam logic [7:0] HDR0        = 8'hAA;
    localparam logic [7:0] HDR1        = 8'h55;
    localparam int         PKT_LEN     = 8;
    localparam int         FAST_PERIOD = 4096;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    typedef struct packed {
        logic [11:0] batt;
        logic [11:0] curr;
        logic [11:0] torque;
    } snap_t;

    // Readings go out high nibble first, zero-extended to a full byte.
    function automatic logic [7:0] pkt_byte(input snap_t s, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HDR0;
            3'd1:    b = HDR1;
            3'd2:    b = {4'h0, s.batt[11:8]};
            3'd3:    b = s.batt[7:0];
            3'd4:    b = {4'h0, s.curr[11:8]};
            3'd5:    b = s.curr[7:0];
            3'd6:    b = {4'h0, s.torque[11:8]};
            default: b = s.torque[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/telem_timer.sv
// Free-running packet-interval counter; pulses tick on the last count of each period.
module telem_timer
    import telem_pkg::*;
#(
    parameter int PERIOD   = 1048576,
    parameter bit FAST_SIM = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int         P    = FAST_SIM ? FAST_PERIOD : PERIOD;
    localparam logic [19:0] LAST = 20'(P - 1);

    logic [19:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (!en || count == LAST)
            count <= '0;
        else
            count <= count + 20'd1;
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/telemetry_sched.sv
// Snapshots battery/current/torque on each period tick and feeds the 8-byte packet to UART_tx.
//   state | meaning
//   IDLE  | no packet in flight, waiting for a period tick
//   SEND  | strobe trmt with byte[idx] on the next cycle
//   WAIT  | byte handed to UART_tx, waiting for tx_done
module telemetry_sched
    import telem_pkg::*;
#(
    parameter int PERIOD   = 1048576,
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] torque,
    input  logic        tx_done,
    input  logic        clr_ovr,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        pkt_done,
    output logic        ovr
);

    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

    logic tick;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    snap_t      snap, snap_nx;
    logic       trmt_nx, busy_nx, pkt_done_nx, ovr_nx;
    logic [7:0] tx_data_nx;

    telem_timer #(
        .PERIOD   (PERIOD),
        .FAST_SIM (FAST_SIM)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            snap     <= '0;
            trmt     <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            snap     <= snap_nx;
            trmt     <= trmt_nx;
            tx_data  <= tx_data_nx;
            busy     <= busy_nx;
            pkt_done <= pkt_done_nx;
            ovr      <= ovr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        snap_nx     = snap;
        trmt_nx     = 1'b0;
        tx_data_nx  = tx_data;
        busy_nx     = busy;
        pkt_done_nx = 1'b0;

        case (state)
            IDLE: begin
                if (tick) begin
                    snap_nx    = '{batt: batt, curr: curr, torque: torque};
                    idx_nx     = '0;
                    busy_nx    = 1'b1;
                    trmt_nx    = 1'b1;
                    tx_data_nx = HDR0;
                    state_nx   = WAIT;
                end
            end
            SEND: begin
                trmt_nx    = 1'b1;
                tx_data_nx = pkt_byte(snap, idx);
                state_nx   = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx != LAST_IDX) begin
                        idx_nx   = idx + 3'd1;
                        state_nx = SEND;
                    end else begin
                        busy_nx     = 1'b0;
                        pkt_done_nx = 1'b1;
                        state_nx    = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A tick landing mid-packet is dropped, not queued; the set beats a simultaneous clear.
        ovr_nx = ovr;
        if (clr_ovr)
            ovr_nx = 1'b0;
        if (tick && state != IDLE)
            ovr_nx = 1'b1;
    end

endmodule
